// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// forwarding-select codes used by the ID-stage operand muxes.
package hazard_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_LDSTALL = 3'd1,
      ST_FLUSH   = 3'd2,
      ST_MDWAIT  = 3'd3,
      ST_HALT    = 3'd4
   } hz_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ID-stage operand; the younger EX/MEM result
// shadows the older MEM/WB result when both target the same register.
module fwd_sel
   import hazard_pkg::*;
(
   input  logic [3:0] rs,
   input  logic       mem_regWrite,
   input  logic [3:0] mem_regDes,
   input  logic       wb_regWrite,
   input  logic [3:0] wb_regDes,
   output logic [1:0] fwd
);

   // Priority select: EX/MEM, then MEM/WB, then register file
   always_comb begin
      fwd = FWD_RF;
      if (mem_regWrite && (mem_regDes == rs)) begin
         fwd = FWD_MEM;
      end else if (wb_regWrite && (wb_regDes == rs)) begin
         fwd = FWD_WB;
      end else begin
         fwd = FWD_RF;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage core: load-use stalls,
// branch flushes, multi-cycle MUL/DIV holds, halt, and bring-up counters.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_rs1,
   input  logic [3:0]       id_rs2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic             ex_memRead,
   input  logic             ex_regWrite,
   input  logic [3:0]       ex_regDes,
   input  logic             ex_muldiv,
   input  logic             ex_brTaken,
   input  logic             mem_regWrite,
   input  logic             wb_regWrite,
   input  logic [3:0]       mem_regDes,
   input  logic [3:0]       wb_regDes,
   input  logic             halt_req,
   output logic             pcWrite,
   output logic             ifidWrite,
   output logic             idexHold,
   output logic             ifidFlush,
   output logic             idexFlush,
   output logic [1:0]       fwd1,
   output logic [1:0]       fwd2,
   output logic             mdBusy,
   output logic             halted,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
);

   // One spare bit keeps the counter at least 2 bits wide for MD_LAT=2
   localparam int MD_W = $clog2(MD_LAT) + 1;
   localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT - 2);

   hz_state_e        state_r;
   hz_state_e        state_nxt_s;
   logic [MD_W-1:0]  md_cnt_r;
   logic [MD_W-1:0]  md_nxt_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;
   logic             flush_inc_s;
   logic             stall_inc_s;
   logic             lu_s;
   logic [1:0]       fwd1_s;
   logic [1:0]       fwd2_s;

   assign lu_s = ex_memRead & ex_regWrite &
                 ((id_use1 & (id_rs1 == ex_regDes)) |
                  (id_use2 & (id_rs2 == ex_regDes)));

   fwd_sel u_fwd1 (
      .rs           (id_rs1),
      .mem_regWrite (mem_regWrite),
      .mem_regDes   (mem_regDes),
      .wb_regWrite  (wb_regWrite),
      .wb_regDes    (wb_regDes),
      .fwd          (fwd1_s)
   );

   fwd_sel u_fwd2 (
      .rs           (id_rs2),
      .mem_regWrite (mem_regWrite),
      .mem_regDes   (mem_regDes),
      .wb_regWrite  (wb_regWrite),
      .wb_regDes    (wb_regDes),
      .fwd          (fwd2_s)
   );

   assign fwd1 = rst ? FWD_RF : fwd1_s;
   assign fwd2 = rst ? FWD_RF : fwd2_s;

   // Next-state and zero-latency control outputs
   always_comb begin
      pcWrite     = 1'b1;
      ifidWrite   = 1'b1;
      idexHold    = 1'b0;
      ifidFlush   = 1'b0;
      idexFlush   = 1'b0;
      mdBusy      = 1'b0;
      halted      = 1'b0;
      flush_inc_s = 1'b0;
      state_nxt_s = state_r;
      md_nxt_s    = md_cnt_r;
      if (rst) begin
         pcWrite     = 1'b0;
         ifidWrite   = 1'b0;
         ifidFlush   = 1'b1;
         idexFlush   = 1'b1;
         state_nxt_s = ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (halt_req) begin
                  pcWrite     = 1'b0;
                  ifidWrite   = 1'b0;
                  idexFlush   = 1'b1;
                  state_nxt_s = ST_HALT;
               end else if (ex_brTaken) begin
                  ifidFlush   = 1'b1;
                  idexFlush   = 1'b1;
                  flush_inc_s = 1'b1;
                  state_nxt_s = ST_FLUSH;
               end else if (ex_muldiv) begin
                  pcWrite     = 1'b0;
                  ifidWrite   = 1'b0;
                  idexHold    = 1'b1;
                  md_nxt_s    = MD_LOAD;
                  state_nxt_s = ST_MDWAIT;
               end else if (lu_s) begin
                  pcWrite     = 1'b0;
                  ifidWrite   = 1'b0;
                  idexFlush   = 1'b1;
                  state_nxt_s = ST_LDSTALL;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            // ID holds either the re-issued consumer or a bubble: no new lu check
            ST_LDSTALL, ST_FLUSH: begin
               state_nxt_s = ST_RUN;
            end
            ST_MDWAIT: begin
               if (md_cnt_r == {MD_W{1'b0}}) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  pcWrite     = 1'b0;
                  ifidWrite   = 1'b0;
                  idexHold    = 1'b1;
                  mdBusy      = 1'b1;
                  md_nxt_s    = md_cnt_r - MD_W'(1);
                  state_nxt_s = ST_MDWAIT;
               end
            end
            ST_HALT: begin
               pcWrite     = 1'b0;
               ifidWrite   = 1'b0;
               idexFlush   = 1'b1;
               halted      = 1'b1;
               state_nxt_s = ST_HALT;
            end
            default: begin
               pcWrite     = 1'b0;
               ifidWrite   = 1'b0;
               idexFlush   = 1'b1;
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   assign stall_inc_s = ~pcWrite & (state_r != ST_HALT);

   // State, MD down-counter and saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_RUN;
         md_cnt_r    <= {MD_W{1'b0}};
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         md_cnt_r <= md_nxt_s;
         if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end
         if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
         end
      end
   end

   assign stallCnt = stall_cnt_r;
   assign flushCnt = flush_cnt_r;

endmodule
